// File: rtl/alu_mdu_pkg.sv
// Shared decode constants, MDU state encoding and the MDU request type.
package alu_mdu_pkg;

    // Main-control ALU op classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_MEM   = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;

    // funct[1] selects divide, funct[0] selects the unsigned variant
    typedef struct packed {
        logic is_div;
        logic is_signed;
    } mdu_req_t;

endpackage

// File: rtl/alu_mdu_pipeline_mdu_iter.sv
// Iterative multiply/divide: WIDTH shift-add or restoring-divide steps on
// operand magnitudes, one sign fix-up cycle, then HI/LO commit.
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  mdu_req_t         req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    mdu_state_t       state;
    logic [CNT_W-1:0] cnt;
    mdu_req_t         op_q;
    logic             neg_q, negr_q, dz_q;
    logic [WIDTH-1:0] araw_q, acc_hi, acc_lo, dvs_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_r, div_d;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix, res_hi;

    assign a_neg = req.is_signed & a[WIDTH-1];
    assign b_neg = req.is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One multiply step: conditionally add multiplicand into the high half
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs_q} : '0);
    // One divide step: shift next dividend bit into the partial remainder
    assign div_r   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_d   = div_r - {1'b0, dvs_q};

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = neg_q ? -acc_lo : acc_lo;
    assign r_fix    = negr_q ? -acc_hi : acc_hi;

    // Divide by zero bypasses the sign fix-up: LO all ones, HI the raw dividend
    always_comb begin
        if (op_q.is_div) begin
            res_lo = dz_q ? '1 : q_fix;
            res_hi = dz_q ? araw_q : r_fix;
        end else begin
            res_lo = prod_fix[WIDTH-1:0];
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIX);

    // Sequencer and datapath: load, iterate WIDTH times, fix-up and commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
            araw_q <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            dvs_q  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q   <= req;
                    neg_q  <= a_neg ^ b_neg;
                    negr_q <= a_neg;
                    dz_q   <= (b == '0);
                    araw_q <= a;
                    acc_hi <= '0;
                    acc_lo <= a_mag;
                    dvs_q  <= b_mag;
                    cnt    <= CNT_W'(WIDTH - 1);
                    state  <= req.is_div ? DIV : MUL;
                end
                MUL: begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                DIV: begin
                    if (!div_d[WIDTH]) begin
                        acc_hi <= div_d[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_r[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alu_mdu_pipeline.sv
// Execute-stage ALU: single-cycle decode with registered result, plus an
// iterative multiply/divide unit that stalls the front end via busy.
module alu_mdu_pipeline
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       aluOP,
    input  logic [5:0]       sel,
    output logic [WIDTH-1:0] ans,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic             is_sub, ovf_raw, mdu_op, accept, done;
    logic [WIDTH-1:0] b_add, sum, ans_nx, mdu_lo;
    logic             zero_nx, ovf_nx;
    mdu_req_t         req;

    assign is_sub  = (aluOP == ALUOP_SUB) || (aluOP == ALUOP_RTYPE && sel == FN_SUB);
    assign b_add   = is_sub ? (~b + 1'b1) : b;
    assign sum     = a + b_add;
    assign ovf_raw = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign req     = '{is_div: sel[1], is_signed: ~sel[0]};

    // Single-cycle result decode; flags mdu ops so they go to the iterator
    always_comb begin
        ans_nx  = '0;
        zero_nx = 1'b0;
        ovf_nx  = 1'b0;
        mdu_op  = 1'b0;
        case (aluOP)
            ALUOP_ADD, ALUOP_MEM: begin
                ans_nx = sum;
                ovf_nx = ovf_raw;
            end
            ALUOP_SUB: begin
                ans_nx  = sum;
                ovf_nx  = ovf_raw;
                zero_nx = (sum == '0);
            end
            default: begin
                case (sel)
                    FN_ADD, FN_SUB: begin
                        ans_nx = sum;
                        ovf_nx = ovf_raw;
                    end
                    FN_AND:  ans_nx = a & b;
                    FN_OR:   ans_nx = a | b;
                    FN_XOR:  ans_nx = a ^ b;
                    FN_NOR:  ans_nx = ~(a | b);
                    FN_SLT:  ans_nx = WIDTH'($signed(a) < $signed(b));
                    FN_SLTU: ans_nx = WIDTH'(a < b);
                    FN_MFHI: ans_nx = hi;
                    FN_MFLO: ans_nx = lo;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: mdu_op = 1'b1;
                    default: ans_nx = '0;
                endcase
            end
        endcase
    end

    assign in_ready = ~busy;
    assign accept   = in_valid & in_ready;

    mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (accept & mdu_op),
        .req    (req),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .res_lo (mdu_lo),
        .hi     (hi),
        .lo     (lo)
    );

    // Output register: single-cycle result or mdu LO the cycle after fix-up
    always_ff @(posedge clk) begin
        if (rst) begin
            ans       <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept && !mdu_op) begin
            ans       <= ans_nx;
            zero      <= zero_nx;
            ovf       <= ovf_nx;
            out_valid <= 1'b1;
        end else if (done) begin
            ans       <= mdu_lo;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule
